traffic_phase_scheduler: RTL and testbench
==========================================

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter ALL_RED_TIME, default 2, all-red clearance duration in ticks.
REQ-002 Parameter MIN_GREEN, default 5, minimum green duration in ticks.
REQ-003 Parameter MAX_GREEN, default 20, maximum green duration in ticks.
REQ-004 Parameter YELLOW_TIME, default 3, yellow duration in ticks.
REQ-005 Parameter legality: all values in 1..255; MIN_GREEN <= MAX_GREEN.
REQ-006 clk  input  1  clock.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 tick  input  1  one-cycle timebase strobe; all timers advance only on clk edges with tick=1.
REQ-009 car_present  input  4  demand per lane: [0]=NS1, [1]=NS2, [2]=EW1, [3]=EW2.
REQ-010 emerg_req  input  1  emergency preemption request; level-sensitive.
REQ-011 emerg_lane  input  2  lane index requested by emerg_req.
REQ-012 light_signal  output  4  registered phase code: 0=all red; lane L green=2L+1; lane L yellow=2L+2.
REQ-013 active_lane  output  2  registered index of the lane currently green or yellow, or last served when all red.
REQ-014 phase_change  output  1  registered one-cycle pulse, high the cycle after any light_signal change.

Function
REQ-015 States: ALL_RED, GREEN, YELLOW; light_signal = 0, 2L+1, 2L+2 respectively, updated on the same edge as the state.
REQ-016 Timer: 8 bits, cleared on state entry, incremented on tick, saturating at 255; elapsed = timer+1 on the evaluating tick.
REQ-017 ALL_RED exits on the tick where elapsed = ALL_RED_TIME; exit goes to GREEN of the selected lane.
REQ-018 Lane selection: round-robin search starting at active_lane+1 (mod 4); picks the first lane with car_present=1; if none, picks active_lane+1.
REQ-019 GREEN exits to YELLOW on the tick where elapsed >= MIN_GREEN and (car_present[L]=0 or elapsed >= MAX_GREEN).
REQ-020 YELLOW exits to ALL_RED on the tick where elapsed = YELLOW_TIME.
REQ-021 car_present is sampled only on tick cycles; changes between ticks have no effect.
REQ-022 With tick=0, state, timer and all outputs hold indefinitely.
REQ-023 No state other than ALL_RED may exist between YELLOW and GREEN; a green-to-green transition without yellow and all-red is forbidden.
REQ-024 Illegal state encodings return to ALL_RED on the next edge.

Reset
REQ-025 rst=1 immediately forces ALL_RED, light_signal=0, active_lane=3, phase_change=0, timer=0, regardless of clk.
REQ-026 Reset during any state, including mid-YELLOW, restarts at ALL_RED; the first selection searches from lane 0.
REQ-027 rst deassertion is synchronous to clk.

Configuration
REQ-028 Macro EMERGENCY_PREEMPT_EN enables emergency preemption; emerg_req and emerg_lane ports exist in both builds.
REQ-029 Without the macro, emerg_req and emerg_lane are ignored.
REQ-030 With the macro, emerg_req=1 in GREEN of a lane other than emerg_lane goes to YELLOW at the next tick, bypassing MIN_GREEN.
REQ-031 With the macro, YELLOW and ALL_RED complete normally, and the next selection is forced to emerg_lane while emerg_req=1.
REQ-032 With the macro, GREEN of emerg_lane does not exit while emerg_req=1, ignoring MAX_GREEN; normal REQ-019 rules resume once emerg_req=0.

Verification
REQ-033 Defaults, tick every cycle, car_present=0 -> codes 0(2 ticks), 1(5), 2(3), 0(2), 3(5), 4(3), 0(2), 5(5), ... repeating 1,3,5,7 order.
REQ-034 car_present=4'b0100 held -> after reset, 0(2) then 5(20), 6(3), 0(2), 5 again; NS1, NS2 and EW2 are never green.
REQ-035 car_present[0]=1 until just before the 9th green tick, then 0 -> code 1 lasts exactly 9 ticks, then 2.
REQ-036 tick low for 100 cycles mid-GREEN -> light_signal, active_lane constant, phase_change=0; rst pulse mid-YELLOW -> light_signal=0 within the same cycle, and the next green is code 1.
REQ-037 EMERGENCY_PREEMPT_EN defined, NS1 green at elapsed=2, emerg_req=1 with emerg_lane=2 -> 2 next tick (3 ticks), 0(2), 5 held while emerg_req=1; without the macro -> NS1 green continues to MIN/MAX rules.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//
// Four-lane traffic light phase scheduler. One lane at a time goes
// GREEN -> YELLOW -> ALL_RED, and the next lane is then picked round-robin
// from the lanes that have demand. All timing is counted in ticks of an
// external timebase strobe.
//
// Ports
//   clk           clock
//   rst           asynchronous, active-high reset (deassertion synchronous to clk)
//   tick          one-cycle timebase strobe; timers advance only when high
//   car_present   per-lane demand: [0]=NS1 [1]=NS2 [2]=EW1 [3]=EW2
//   emerg_req     emergency preemption request (level)
//   emerg_lane    lane requested by emerg_req
//   light_signal  phase code: 0=all red, lane L green=2L+1, lane L yellow=2L+2
//   active_lane   lane currently green/yellow, or last served while all red
//   phase_change  one-cycle pulse in the cycle after light_signal changes
//
// Configuration macro
//   EMERGENCY_PREEMPT_EN  enables emergency preemption. Without it the
//                         emerg_req/emerg_lane ports exist but are ignored.
//
// Parameters must lie in 1..255 with MIN_GREEN <= MAX_GREEN.

module traffic_phase_scheduler #(
  parameter int unsigned ALL_RED_TIME = 2,
  parameter int unsigned MIN_GREEN    = 5,
  parameter int unsigned MAX_GREEN    = 20,
  parameter int unsigned YELLOW_TIME  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] car_present,
  input  logic       emerg_req,
  input  logic [1:0] emerg_lane,
  output logic [3:0] light_signal,
  output logic [1:0] active_lane,
  output logic       phase_change
);

  localparam logic [1:0] S_ALL_RED = 2'd0;
  localparam logic [1:0] S_GREEN   = 2'd1;
  localparam logic [1:0] S_YELLOW  = 2'd2;

  // Durations widened to the 9-bit elapsed value so that a saturated
  // timer (elapsed = 256) still compares correctly.
  localparam logic [8:0] ALL_RED_LIM = 9'(ALL_RED_TIME);
  localparam logic [8:0] MIN_LIM     = 9'(MIN_GREEN);
  localparam logic [8:0] MAX_LIM     = 9'(MAX_GREEN);
  localparam logic [8:0] YELLOW_LIM  = 9'(YELLOW_TIME);

  logic [1:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] lane_q, lane_d;
  logic [3:0] light_q, light_d;
  logic       phase_change_q, phase_change_d;

  logic [8:0] elapsed;
  logic [7:0] timer_inc;
  logic [1:0] cand [4];
  logic [3:0] hit;
  logic [1:0] rr_lane;
  logic [1:0] sel_lane;
  logic       green_exit;

  // Elapsed ticks including the one being evaluated now.
  assign elapsed   = {1'b0, timer_q} + 9'd1;
  assign timer_inc = (timer_q == 8'hFF) ? 8'hFF : timer_q + 8'd1;

  // Round-robin candidates: offset 1..4 from the last served lane. Offset 4
  // wraps back to the last served lane itself, so it is considered last.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = lane_q + 2'(gi + 1);
      assign hit[gi]  = car_present[cand[gi]];
    end
  endgenerate

  // First candidate with demand wins; with no demand at all, step to the
  // next lane so an idle junction still cycles through every lane.
  always_comb begin
    rr_lane = lane_q + 2'd1;
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) rr_lane = cand[i];
    end
  end

`ifdef EMERGENCY_PREEMPT_EN
  // An active request forces the next green to the requested lane, cuts a
  // conflicting green short (ignoring MIN_GREEN) and holds a matching green
  // indefinitely (ignoring MAX_GREEN).
  always_comb begin
    sel_lane = emerg_req ? emerg_lane : rr_lane;
    if (emerg_req) begin
      green_exit = (emerg_lane != lane_q);
    end else begin
      green_exit = (elapsed >= MIN_LIM) &&
                   (!car_present[lane_q] || (elapsed >= MAX_LIM));
    end
  end
`else
  logic unused_emerg;
  assign unused_emerg = ^{emerg_req, emerg_lane};

  always_comb begin
    sel_lane   = rr_lane;
    green_exit = (elapsed >= MIN_LIM) &&
                 (!car_present[lane_q] || (elapsed >= MAX_LIM));
  end
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lane_d  = lane_q;
    case (state_q)
      S_ALL_RED: begin
        if (tick) begin
          if (elapsed == ALL_RED_LIM) begin
            state_d = S_GREEN;
            lane_d  = sel_lane;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      S_GREEN: begin
        if (tick) begin
          if (green_exit) begin
            state_d = S_YELLOW;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      S_YELLOW: begin
        if (tick) begin
          if (elapsed == YELLOW_LIM) begin
            state_d = S_ALL_RED;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      default: begin
        // Unused encoding: fall back to the safe all-red phase.
        state_d = S_ALL_RED;
        timer_d = 8'd0;
      end
    endcase

    // Output code tracks the next state so it changes on the same edge.
    case (state_d)
      S_GREEN:  light_d = {1'b0, lane_d, 1'b1};
      S_YELLOW: light_d = {1'b0, lane_d, 1'b0} + 4'd2;
      default:  light_d = 4'd0;
    endcase

    phase_change_d = (light_d != light_q);
  end

  // Reset leaves active_lane at 3 so the first search starts at lane 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_ALL_RED;
      timer_q        <= 8'd0;
      lane_q         <= 2'd3;
      light_q        <= 4'd0;
      phase_change_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      lane_q         <= lane_d;
      light_q        <= light_d;
      phase_change_q <= phase_change_d;
    end
  end

  assign light_signal = light_q;
  assign active_lane  = lane_q;
  assign phase_change = phase_change_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

  localparam int ALL_RED_TIME = 2;
  localparam int MIN_GREEN    = 5;
  localparam int MAX_GREEN    = 20;
  localparam int YELLOW_TIME  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] car;
  logic       er;
  logic [1:0] el;
  logic [3:0] light;
  logic [1:0] lane;
  logic       pc;

  int n_pass  = 0;
  int n_total = 0;

  traffic_phase_scheduler #(
    .ALL_RED_TIME(ALL_RED_TIME),
    .MIN_GREEN   (MIN_GREEN),
    .MAX_GREEN   (MAX_GREEN),
    .YELLOW_TIME (YELLOW_TIME)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .car_present (car),
    .emerg_req   (er),
    .emerg_lane  (el),
    .light_signal(light),
    .active_lane (lane),
    .phase_change(pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Phase kind: 0 all red, 1 green, 2 yellow; m_time = ticks already spent.
  int m_kind, m_lane, m_time, m_code, m_pc;

  function automatic int code_of(input int k, input int l);
    return (k == 0) ? 0 : 2 * l + k;
  endfunction

  task automatic model_reset();
    m_kind = 0; m_lane = 3; m_time = 0; m_code = 0; m_pc = 0;
  endtask

  task automatic model_advance(input logic t, input logic [3:0] c,
                               input logic e, input logic [1:0] l);
    int prev;
    int elp;
    int pick;
    bit go;
    prev = m_code;
    if (t) begin
      elp = m_time + 1;
      if (m_kind == 0) begin
        if (elp == ALL_RED_TIME) begin
          pick = (m_lane + 1) % 4;
          for (int i = 4; i >= 1; i--)
            if (c[(m_lane + i) % 4]) pick = (m_lane + i) % 4;
`ifdef EMERGENCY_PREEMPT_EN
          if (e) pick = int'(l);
`endif
          m_lane = pick; m_kind = 1; m_time = 0;
        end else m_time = elp;
      end else if (m_kind == 1) begin
        go = (elp >= MIN_GREEN) && (!c[m_lane] || elp >= MAX_GREEN);
`ifdef EMERGENCY_PREEMPT_EN
        if (e) go = (int'(l) != m_lane);
`endif
        if (go) begin m_kind = 2; m_time = 0; end
        else m_time = elp;
      end else begin
        if (elp == YELLOW_TIME) begin m_kind = 0; m_time = 0; end
        else m_time = elp;
      end
    end
    m_code = code_of(m_kind, m_lane);
    m_pc   = (m_code != prev) ? 1 : 0;
  endtask

  // ---------------- helpers ----------------
  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; car = 4'd0; er = 1'b0; el = 2'd0;
    @(posedge clk); #1;
    chk("reset_light", int'(light), 0);
    chk("reset_lane", int'(lane), 3);
    chk("reset_pc", int'(pc), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_code(input string name, input int code, input int bound);
    int i;
    i = 0;
    while (int'(light) != code && i < bound) begin step(); i++; end
    chk(name, int'(light), code);
  endtask

  // Counts cycles (including the current one) showing code, up to bound.
  task automatic run_len(input int code, input int bound, output int n);
    n = 0;
    while (int'(light) == code && n < bound) begin n++; step(); end
  endtask

  typedef struct {
    logic       t;
    logic [3:0] c;
    int         code;
    int         ln;
    int         pcx;
  } vec_t;

  vec_t vecs [15];
  int   n;
  int   bad;

  initial begin
    rst = 1'b1; tick = 1'b0; car = 4'd0; er = 1'b0; el = 2'd0;

    // Idle junction, tick every cycle: 0(2) 1(5) 2(3) 0(2) 3..., with one
    // tick-free cycle carrying bogus demand that must be ignored.
    vecs[0]  = '{1'b1, 4'h0, 0, 3, 0};
    vecs[1]  = '{1'b1, 4'h0, 1, 0, 1};
    vecs[2]  = '{1'b1, 4'h0, 1, 0, 0};
    vecs[3]  = '{1'b1, 4'h0, 1, 0, 0};
    vecs[4]  = '{1'b0, 4'hF, 1, 0, 0};
    vecs[5]  = '{1'b1, 4'h0, 1, 0, 0};
    vecs[6]  = '{1'b1, 4'h0, 1, 0, 0};
    vecs[7]  = '{1'b1, 4'h0, 2, 0, 1};
    vecs[8]  = '{1'b1, 4'h0, 2, 0, 0};
    vecs[9]  = '{1'b1, 4'h0, 2, 0, 0};
    vecs[10] = '{1'b1, 4'h0, 0, 0, 1};
    vecs[11] = '{1'b1, 4'h0, 0, 0, 0};
    vecs[12] = '{1'b1, 4'h0, 3, 1, 1};
    vecs[13] = '{1'b1, 4'h0, 3, 1, 0};
    vecs[14] = '{1'b0, 4'h0, 3, 1, 0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      tick = vecs[i].t; car = vecs[i].c;
      step();
      chk($sformatf("vec%0d_light", i), int'(light), vecs[i].code);
      chk($sformatf("vec%0d_lane", i), int'(lane), vecs[i].ln);
      chk($sformatf("vec%0d_pc", i), int'(pc), vecs[i].pcx);
      $display("vec %0d: tick=%0d car=%h light=%0d lane=%0d pc=%0d",
               i, vecs[i].t, vecs[i].c, light, lane, pc);
    end

    // Only EW1 has demand: it keeps winning and runs to MAX_GREEN.
    do_reset();
    car = 4'b0100; tick = 1'b1;
    wait_code("ew1_first_green", 5, 10);
    run_len(5, 40, n); chk("ew1_green_len", n, MAX_GREEN);
    chk("ew1_yellow", int'(light), 6);
    run_len(6, 10, n); chk("ew1_yellow_len", n, YELLOW_TIME);
    run_len(0, 10, n); chk("ew1_red_len", n, ALL_RED_TIME);
    chk("ew1_again", int'(light), 5);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (light != 4'd0 && light != 4'd5 && light != 4'd6) bad++;
    end
    chk("ew1_only_lane", bad, 0);
    $display("seq ew1_only: done");

    // NS1 demand removed just before its 9th green tick.
    do_reset();
    car = 4'b0001; tick = 1'b1;
    wait_code("ns1_green", 1, 10);
    for (int i = 0; i < 8; i++) step();
    chk("ns1_still_green", int'(light), 1);
    car = 4'b0000;
    step();
    chk("ns1_yellow_after_9", int'(light), 2);
    $display("seq ns1_9ticks: done");

    // Tick stalled mid-green, then asynchronous reset mid-yellow.
    do_reset();
    tick = 1'b1;
    wait_code("stall_green", 1, 10);
    step(); step();
    tick = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      car = 4'($urandom);
      step();
      if (light != 4'd1 || lane != 2'd0 || pc != 1'b0) bad++;
    end
    chk("stall_hold", bad, 0);
    car = 4'd0; tick = 1'b1;
    wait_code("mid_yellow", 2, 20);
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_light", int'(light), 0);
    chk("async_rst_lane", int'(lane), 3);
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (light == 4'd0 && n < 10) begin step(); n++; end
    chk("after_rst_green", int'(light), 1);
    $display("seq stall_and_reset: done");

    // Emergency request for EW1 while NS1 is green at elapsed=2.
    do_reset();
    car = 4'b0001; tick = 1'b1;
    wait_code("emerg_ns1_green", 1, 10);
    step(); step();
    er = 1'b1; el = 2'd2;
`ifdef EMERGENCY_PREEMPT_EN
    step();
    chk("emerg_yellow", int'(light), 2);
    run_len(2, 10, n); chk("emerg_yellow_len", n, YELLOW_TIME);
    run_len(0, 10, n); chk("emerg_red_len", n, ALL_RED_TIME);
    chk("emerg_green_ew1", int'(light), 5);
    run_len(5, 40, n); chk("emerg_hold", n, 40);
    er = 1'b0;
    step();
    chk("emerg_release", int'(light), 6);
`else
    run_len(1, 40, n); chk("no_emerg_green_rest", n, MAX_GREEN - 2);
    chk("no_emerg_yellow", int'(light), 2);
    er = 1'b0;
`endif
    $display("seq emergency: done");

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) car = 4'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        er = ~er; el = 2'($urandom_range(0, 3));
      end
      model_advance(tick, car, er, el);
      step();
      chk($sformatf("rand%0d_light", i), int'(light), m_code);
      chk($sformatf("rand%0d_lane", i), int'(lane), m_lane);
      chk($sformatf("rand%0d_pc", i), int'(pc), m_pc);
    end
    $display("seq random: 3000 cycles done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
